// File: rtl/cc_br_ctrl_if.sv
// cc_br_ctrl_if: handshake and strobe bundle between the LC-3 sequencer and its datapath
// Inputs to the sequencer: run_i, ir_i, bus_i, nzp_i, mem_rdy_i.
// Outputs from the sequencer: ld_mar, ld_mdr, ld_ir, ld_pc, pc_sel, ld_reg, ld_cc,
// nzp_o, mem_oe, halted_o, err_o, state_o.
interface cc_br_ctrl_if;
  logic        run_i;
  logic [15:0] ir_i;
  logic [15:0] bus_i;
  logic [2:0]  nzp_i;
  logic        mem_rdy_i;
  logic        ld_mar;
  logic        ld_mdr;
  logic        ld_ir;
  logic        ld_pc;
  logic [1:0]  pc_sel;
  logic        ld_reg;
  logic        ld_cc;
  logic [2:0]  nzp_o;
  logic        mem_oe;
  logic        halted_o;
  logic        err_o;
  logic [3:0]  state_o;
  modport master (
    output run_i, ir_i, bus_i, nzp_i, mem_rdy_i,
    input  ld_mar, ld_mdr, ld_ir, ld_pc, pc_sel, ld_reg, ld_cc, nzp_o, mem_oe, halted_o, err_o, state_o
  );
  modport slave (
    input  run_i, ir_i, bus_i, nzp_i, mem_rdy_i,
    output ld_mar, ld_mdr, ld_ir, ld_pc, pc_sel, ld_reg, ld_cc, nzp_o, mem_oe, halted_o, err_o, state_o
  );
endinterface

// File: rtl/cc_br_ctrl.sv
// cc_br_ctrl: LC-3 fetch/decode/execute sequencer owning condition-code generation and BR resolution
// clk   : rising-edge clock
// reset : asynchronous active-low reset, forces IDLE
// cc    : slave side of cc_br_ctrl_if (run/IR/bus/CC/memory-ready in, load strobes and status out)
module cc_br_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input logic         clk,
  input logic         reset,
  cc_br_ctrl_if.slave cc
);
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    F1    = 4'd1,
    F2    = 4'd2,
    F3    = 4'd3,
    DEC   = 4'd4,
    ALU   = 4'd5,
    BR    = 4'd6,
    PAUSE = 4'd7,
    ERR   = 4'd8
  } state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             run_q, err_q;
  logic             run_rise, taken, is_alu;
  logic [3:0]       op;
  logic             unused_ir;
  assign op        = cc.ir_i[15:12];
  assign unused_ir = ^cc.ir_i[8:0];
  assign run_rise  = cc.run_i & ~run_q;
  assign taken     = |(cc.ir_i[11:9] & cc.nzp_i);
  assign is_alu    = (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1001);
  assign cnt_inc   = cnt_q + 1'b1;
  assign cc.nzp_o  = cc.bus_i[15] ? 3'b100 : (cc.bus_i == 16'h0000) ? 3'b010 : 3'b001;
  assign cc.halted_o = (state_q == PAUSE) || (state_q == ERR);
  assign cc.err_o    = err_q;
  assign cc.state_o  = state_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= cc.run_i;
      err_q   <= err_q | (state_d == ERR);
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cc.ld_mar = 1'b0;
    cc.ld_mdr = 1'b0;
    cc.ld_ir  = 1'b0;
    cc.ld_pc  = 1'b0;
    cc.pc_sel = 2'b00;
    cc.ld_reg = 1'b0;
    cc.ld_cc  = 1'b0;
    cc.mem_oe = 1'b0;
    case (state_q)
      IDLE:  state_d = cc.run_i ? F1 : IDLE;
      F1: begin
        cc.ld_mar = 1'b1;
        cc.ld_pc  = 1'b1;
        cnt_d     = '0;
        state_d   = F2;
      end
      F2: begin
        cc.mem_oe = 1'b1;
        cc.ld_mdr = cc.mem_rdy_i;
        cnt_d     = cnt_inc;
        // Data arriving on the final allowed cycle still completes the fetch.
        state_d   = cc.mem_rdy_i ? F3 : (cnt_inc == CNT_W'(MEM_TIMEOUT)) ? ERR : F2;
      end
      F3: begin
        cc.ld_ir = 1'b1;
        state_d  = DEC;
      end
      DEC:   state_d = is_alu ? ALU : (op == 4'b0000) ? BR : (op == 4'b1101) ? PAUSE : F1;
      ALU: begin
        cc.ld_reg = 1'b1;
        cc.ld_cc  = 1'b1;
        state_d   = F1;
      end
      BR: begin
        cc.ld_pc  = taken;
        cc.pc_sel = taken ? 2'b01 : 2'b00;
        state_d   = F1;
      end
      PAUSE: state_d = run_rise ? F1 : PAUSE;
      ERR:   state_d = ERR;
      default: state_d = IDLE;
    endcase
  end
endmodule
